id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 8-register MIPS-style core, with load-use interlock.
- Captures decoded operands and control from ID each cycle and presents them to EX.
- Its ex_rs1/ex_rs2/ex_rd/ex_regwrite outputs feed the operand-forwarding unit and ALU muxes.
- Inserts bubbles on load-use hazards and branch flushes, freezes on downstream hold, and counts bubbles inserted.

---
 rtl/id_ex_stage_pkg.sv | 30 +++
 rtl/id_ex_stage_load_use_detect.sv | 29 ++
 rtl/id_ex_stage.sv | 132 +++++++++++++
 tb/tb_id_ex_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions: datapath widths, ALU opcodes and the control bundle
// carried from decode through the ID/EX register into execute.
package id_ex_stage_pkg;

  localparam int REG_AW = 3;
  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alusrc;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// instruction in ID; register 0 is compared like any other, as in forwarding.
module load_use_detect
  import id_ex_stage_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          i_ex_valid,
  input  logic          i_ex_memread,
  input  logic          i_ex_regwrite,
  input  logic [AW-1:0] i_ex_rd,
  input  logic          i_id_valid,
  input  logic [AW-1:0] i_id_rs1,
  input  logic [AW-1:0] i_id_rs2,
  input  logic          i_id_uses_rs1,
  input  logic          i_id_uses_rs2,
  output logic          o_load_use
);

  logic w_exIsLoad;
  logic w_hitRs1;
  logic w_hitRs2;

  assign w_exIsLoad = i_ex_valid & i_ex_memread & i_ex_regwrite;
  assign w_hitRs1   = i_id_uses_rs1 & (i_ex_rd == i_id_rs1);
  assign w_hitRs2   = i_id_uses_rs2 & (i_ex_rd == i_id_rs2);
  assign o_load_use = w_exIsLoad & i_id_valid & (w_hitRs1 | w_hitRs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, flush/hold handling and a
// saturating count of load-use bubbles.
module id_ex_stage #(
  parameter int REG_AW = id_ex_stage_pkg::REG_AW,
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int OP_W   = id_ex_stage_pkg::OP_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rd1_data,
  input  logic [DATA_W-1:0] id_rd2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rd1_data,
  output logic [DATA_W-1:0] ex_rd2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic              ex_alusrc,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [CNT_W-1:0]  bubble_cnt
);

  import id_ex_stage_pkg::*;

  logic              r_valid;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  id_ex_ctrl_t       r_ctrl;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_loadUse;
  id_ex_ctrl_t       w_idCtrl;

  load_use_detect #(.AW(REG_AW)) u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_memread  (r_ctrl.memread),
    .i_ex_regwrite (r_ctrl.regwrite),
    .i_ex_rd       (r_rd),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .o_load_use    (w_loadUse)
  );

  // Side-effecting control is gated by id_valid so a non-instruction never writes.
  assign w_idCtrl = '{
    alu_op:   alu_op_e'(id_alu_op),
    alusrc:   id_alusrc,
    regwrite: id_regwrite & id_valid,
    memread:  id_memread & id_valid,
    memwrite: id_memwrite & id_valid
  };

  assign id_stall = w_loadUse | ex_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_ctrl  <= CTRL_BUBBLE;
      r_cnt   <= '0;
    end else if (flush || (!ex_hold && w_loadUse)) begin
      // Flush outranks hold so a killed instruction cannot linger in EX.
      r_valid <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_ctrl  <= CTRL_BUBBLE;
      if (!flush && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (!ex_hold) begin
      r_valid <= id_valid;
      r_rs1   <= id_rs1;
      r_rs2   <= id_rs2;
      r_rd    <= id_rd;
      r_rd1   <= id_rd1_data;
      r_rd2   <= id_rd2_data;
      r_imm   <= id_imm;
      r_ctrl  <= w_idCtrl;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_rd1_data = r_rd1;
  assign ex_rd2_data = r_rd2;
  assign ex_imm      = r_imm;
  assign ex_alu_op   = r_ctrl.alu_op;
  assign ex_alusrc   = r_ctrl.alusrc;
  assign ex_regwrite = r_ctrl.regwrite;
  assign ex_memread  = r_ctrl.memread;
  assign ex_memwrite = r_ctrl.memwrite;
  assign bubble_cnt  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage; a second instance with a 2-bit
// bubble counter shares the inputs so saturation can be observed.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [2:0]  op;
    logic        alusrc;
    logic        rw;
    logic        mr;
    logic        mw;
  } exOut_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  rs1;
    logic        urs1;
    logic [2:0]  rs2;
    logic        urs2;
    logic [2:0]  rd;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [2:0]  op;
    logic        alusrc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        flush;
    logic        hold;
  } idIn_t;

  typedef enum logic [1:0] {K_CAP, K_BUB, K_HOLD} kind_e;

  typedef struct packed {
    idIn_t       in;
    kind_e       kind;
    logic        stall;
    logic [15:0] cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [2:0]  id_rd;
  logic [15:0] id_rd1_data;
  logic [15:0] id_rd2_data;
  logic [15:0] id_imm;
  logic [2:0]  id_alu_op;
  logic        id_alusrc;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        flush;
  logic        ex_hold;

  logic        aStall, bStall;
  logic        aValid, bValid;
  logic [2:0]  aRs1, aRs2, aRd, bRs1, bRs2, bRd;
  logic [15:0] aRd1, aRd2, aImm, bRd1, bRd2, bImm;
  logic [2:0]  aOp, bOp;
  logic        aAlusrc, aRw, aMr, aMw, bAlusrc, bRw, bMr, bMw;
  logic [15:0] aCnt;
  logic [1:0]  bCnt;

  exOut_t aEx, bEx, expEx;
  int     expCnt;
  int     checks;
  int     failures;
  vec_t   vecs [0:14];

  assign aEx = {aValid, aRs1, aRs2, aRd, aRd1, aRd2, aImm, aOp, aAlusrc, aRw, aMr, aMw};
  assign bEx = {bValid, bRs1, bRs2, bRd, bRd1, bRd2, bImm, bOp, bAlusrc, bRw, bMr, bMw};

  id_ex_stage dutA (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_rd1_data(id_rd1_data), .id_rd2_data(id_rd2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush), .ex_hold(ex_hold),
    .id_stall(aStall), .ex_valid(aValid), .ex_rs1(aRs1), .ex_rs2(aRs2), .ex_rd(aRd),
    .ex_rd1_data(aRd1), .ex_rd2_data(aRd2), .ex_imm(aImm), .ex_alu_op(aOp),
    .ex_alusrc(aAlusrc), .ex_regwrite(aRw), .ex_memread(aMr), .ex_memwrite(aMw),
    .bubble_cnt(aCnt)
  );

  id_ex_stage #(.CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_rd1_data(id_rd1_data), .id_rd2_data(id_rd2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush), .ex_hold(ex_hold),
    .id_stall(bStall), .ex_valid(bValid), .ex_rs1(bRs1), .ex_rs2(bRs2), .ex_rd(bRd),
    .ex_rd1_data(bRd1), .ex_rd2_data(bRd2), .ex_imm(bImm), .ex_alu_op(bOp),
    .ex_alusrc(bAlusrc), .ex_regwrite(bRw), .ex_memread(bMr), .ex_memwrite(bMw),
    .bubble_cnt(bCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic idIn_t mkIn(input logic v, input logic [2:0] rs1, input logic urs1,
                                 input logic [2:0] rs2, input logic urs2, input logic [2:0] rd,
                                 input logic [15:0] rd1, input logic rw, input logic mr,
                                 input logic mw, input logic fl, input logic hd);
    idIn_t r;
    r.valid  = v;
    r.rs1    = rs1;
    r.urs1   = urs1;
    r.rs2    = rs2;
    r.urs2   = urs2;
    r.rd     = rd;
    r.rd1    = rd1;
    r.rd2    = rd1 ^ 16'h0F0F;
    r.imm    = {rd1[7:0], rd1[15:8]};
    r.op     = rd1[2:0] ^ 3'd5;
    r.alusrc = mr | mw;
    r.rw     = rw;
    r.mr     = mr;
    r.mw     = mw;
    r.flush  = fl;
    r.hold   = hd;
    return r;
  endfunction

  function automatic vec_t mkVec(input idIn_t in, input kind_e k, input logic st, input int cnt);
    vec_t r;
    r.in    = in;
    r.kind  = k;
    r.stall = st;
    r.cnt   = cnt[15:0];
    return r;
  endfunction

  function automatic exOut_t captured(input idIn_t in);
    exOut_t r;
    r.valid  = in.valid;
    r.rs1    = in.rs1;
    r.rs2    = in.rs2;
    r.rd     = in.rd;
    r.rd1    = in.rd1;
    r.rd2    = in.rd2;
    r.imm    = in.imm;
    r.op     = in.op;
    r.alusrc = in.alusrc;
    r.rw     = in.rw & in.valid;
    r.mr     = in.mr & in.valid;
    r.mw     = in.mw & in.valid;
    return r;
  endfunction

  task automatic applyStimulus(input idIn_t v);
    id_valid    = v.valid;
    id_rs1      = v.rs1;
    id_uses_rs1 = v.urs1;
    id_rs2      = v.rs2;
    id_uses_rs2 = v.urs2;
    id_rd       = v.rd;
    id_rd1_data = v.rd1;
    id_rd2_data = v.rd2;
    id_imm      = v.imm;
    id_alu_op   = v.op;
    id_alusrc   = v.alusrc;
    id_regwrite = v.rw;
    id_memread  = v.mr;
    id_memwrite = v.mw;
    flush       = v.flush;
    ex_hold     = v.hold;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One ID cycle: check the same-cycle stall, clock it, then check EX and counters.
  task automatic stepVec(input vec_t v, input string tag);
    int expB;
    @(negedge clk);
    applyStimulus(v.in);
    #1;
    checkOutput({tag, ".stallA"}, 64'(aStall), 64'(v.stall));
    checkOutput({tag, ".stallB"}, 64'(bStall), 64'(v.stall));
    @(posedge clk);
    #1;
    case (v.kind)
      K_CAP:   expEx = captured(v.in);
      K_BUB:   expEx = '0;
      default: expEx = expEx;
    endcase
    expCnt = int'(v.cnt);
    expB   = (expCnt > 3) ? 3 : expCnt;
    checkOutput({tag, ".exA"}, 64'(aEx), 64'(expEx));
    checkOutput({tag, ".exB"}, 64'(bEx), 64'(expEx));
    checkOutput({tag, ".cntA"}, 64'(aCnt), 64'(expCnt));
    checkOutput({tag, ".cntB"}, 64'(bCnt), 64'(expB));
  endtask

  initial begin
    idIn_t hz;
    checks   = 0;
    failures = 0;
    expEx    = '0;
    expCnt   = 0;

    vecs[0]  = mkVec(mkIn(1, 2, 1, 3, 1, 4, 16'h1234, 1, 0, 0, 0, 0), K_CAP,  0, 0);
    vecs[1]  = mkVec(mkIn(1, 1, 1, 0, 0, 5, 16'h0100, 1, 1, 0, 0, 0), K_CAP,  0, 0);
    vecs[2]  = mkVec(mkIn(1, 5, 1, 6, 0, 7, 16'hAAAA, 1, 0, 0, 0, 0), K_BUB,  1, 1);
    vecs[3]  = mkVec(mkIn(1, 5, 1, 6, 0, 7, 16'hAAAA, 1, 0, 0, 0, 0), K_CAP,  0, 1);
    vecs[4]  = mkVec(mkIn(1, 0, 0, 0, 0, 5, 16'h0200, 1, 1, 0, 0, 0), K_CAP,  0, 1);
    vecs[5]  = mkVec(mkIn(1, 1, 1, 5, 0, 3, 16'h3333, 0, 0, 1, 0, 0), K_CAP,  0, 1);
    vecs[6]  = mkVec(mkIn(1, 3, 1, 4, 1, 6, 16'h6666, 1, 0, 0, 0, 1), K_HOLD, 1, 1);
    vecs[7]  = mkVec(mkIn(1, 3, 1, 4, 1, 6, 16'h6666, 1, 0, 0, 0, 1), K_HOLD, 1, 1);
    vecs[8]  = mkVec(mkIn(1, 3, 1, 4, 1, 6, 16'h6666, 1, 0, 0, 0, 1), K_HOLD, 1, 1);
    vecs[9]  = mkVec(mkIn(1, 0, 0, 0, 0, 2, 16'h0222, 1, 1, 0, 0, 0), K_CAP,  0, 1);
    vecs[10] = mkVec(mkIn(1, 2, 1, 0, 0, 3, 16'h5555, 1, 0, 0, 1, 1), K_BUB,  1, 1);
    vecs[11] = mkVec(mkIn(0, 2, 1, 2, 1, 6, 16'h0999, 1, 1, 1, 0, 0), K_CAP,  0, 1);
    vecs[12] = mkVec(mkIn(1, 0, 0, 0, 0, 0, 16'h0010, 1, 1, 0, 0, 0), K_CAP,  0, 1);
    vecs[13] = mkVec(mkIn(1, 3, 1, 0, 1, 1, 16'h7777, 1, 0, 0, 0, 0), K_BUB,  1, 2);
    vecs[14] = mkVec(mkIn(1, 3, 1, 0, 1, 1, 16'h7777, 1, 0, 0, 0, 0), K_CAP,  0, 2);

    rst_n = 1'b0;
    applyStimulus('0);
    #2;
    checkOutput("reset.exA", 64'(aEx), 64'(0));
    checkOutput("reset.cntA", 64'(aCnt), 64'(0));
    checkOutput("reset.stallA", 64'(aStall), 64'(0));
    checkOutput("reset.cntB", 64'(bCnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      stepVec(vecs[i], $sformatf("row%0d", i));
    end

    // Five more load-use bubbles: the 2-bit counter pins at 3, the wide one reaches 7.
    for (int i = 0; i < 5; i++) begin
      stepVec(mkVec(mkIn(1, 0, 0, 0, 0, 1, 16'h0A00 + 16'(i), 1, 1, 0, 0, 0), K_CAP, 0, 2 + i),
              $sformatf("satLoad%0d", i));
      stepVec(mkVec(mkIn(1, 1, 1, 2, 0, 4, 16'h0B00 + 16'(i), 1, 0, 0, 0, 0), K_BUB, 1, 3 + i),
              $sformatf("satBub%0d", i));
    end

    // Async reset in the middle of a load-use stall, then restart from reset values.
    stepVec(mkVec(mkIn(1, 0, 0, 0, 0, 1, 16'h0C00, 1, 1, 0, 0, 0), K_CAP, 0, 7), "preRst");
    hz = mkIn(1, 1, 1, 2, 0, 6, 16'h0D0D, 1, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(hz);
    #1;
    checkOutput("midRst.stallBefore", 64'(aStall), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRst.exA", 64'(aEx), 64'(0));
    checkOutput("midRst.validB", 64'(bValid), 64'(0));
    checkOutput("midRst.cntA", 64'(aCnt), 64'(0));
    checkOutput("midRst.cntB", 64'(bCnt), 64'(0));
    checkOutput("midRst.stallA", 64'(aStall), 64'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    expEx  = '0;
    expCnt = 0;
    stepVec(mkVec(hz, K_CAP, 0, 0), "postRst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
